// File: rtl/matrix_softmax_stream.sv
// matrix_softmax_stream: row-wise base-2 softmax over a streamed matrix.
// Each row is buffered, turned into 2^(x-max) in fixed point, summed,
// then every element is divided by the row sum and streamed out in order.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for START; bad sizes answered with ERROR + READY
// LOAD   | capturing one row into the buffer, tracking the signed maximum
// EXP    | replacing each buffered element by 2^(x-max), accumulating sum
// DIVIDE | restoring division (e << FRAC_SIZE) / sum, one bit per cycle
// OUTPUT | presenting one quotient on DATA_OUT for a single cycle

module matrix_softmax_stream #(
    parameter int DATA_SIZE    = 16,
    parameter int CONTROL_SIZE = 4,
    parameter int FRAC_SIZE    = 8,
    parameter int MAX_LENGTH   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 ERROR,
    input  logic                 DATA_IN_ENABLE,
    output logic                 DATA_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    localparam int ONE_FX  = 2 ** FRAC_SIZE;
    localparam int ADDR_W  = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
    localparam int SUM_W   = DATA_SIZE + CONTROL_SIZE;
    localparam int DIFF_W  = DATA_SIZE + 1;
    localparam int SHIFT_W = DIFF_W - FRAC_SIZE;
    localparam int EXP_W   = FRAC_SIZE + 1;
    localparam int REM_W   = SUM_W + 1;
    localparam int CNT_W   = $clog2(DATA_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXP,
        DIVIDE,
        OUTPUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_SIZE-1:0]        size_i_q;
    logic [DATA_SIZE-1:0]        size_j_q;
    logic [DATA_SIZE-1:0]        row_idx;
    logic [CONTROL_SIZE-1:0]     col_idx;
    logic signed [DATA_SIZE-1:0] max_q;
    logic [SUM_W-1:0]            sum_q;
    logic [REM_W-1:0]            rem_q;
    logic [DATA_SIZE-1:0]        quo_q;
    logic [CNT_W-1:0]            div_cnt;

    logic [DATA_SIZE-1:0] row_buf [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0]      addr;
    logic [DATA_SIZE-1:0]   cur_elem;
    logic                   sizes_ok;
    logic                   col_last;
    logic                   row_last;
    logic                   div_last;

    logic [DIFF_W-1:0]      exp_diff;
    logic [SHIFT_W-1:0]     exp_shift;
    logic [FRAC_SIZE-1:0]   exp_frac;
    logic [EXP_W-1:0]       exp_base;
    logic [EXP_W-1:0]       exp_val;

    logic [2*DATA_SIZE-1:0] dividend;
    logic [REM_W-1:0]       rem_in;
    logic [REM_W-1:0]       rem_next;
    logic [DATA_SIZE-1:0]   quo_in;
    logic [DATA_SIZE-1:0]   quo_next;
    logic [REM_W:0]         rem_shift;
    logic [REM_W:0]         divisor;

    // The column index addresses the row buffer in every phase; the
    // latched sizes (never the live inputs) decide where rows and columns end.
    assign addr     = col_idx[ADDR_W-1:0];
    assign cur_elem = row_buf[addr];
    assign sizes_ok = (SIZE_I_IN != '0) && (SIZE_J_IN != '0)
                      && (SIZE_J_IN <= DATA_SIZE'(MAX_LENGTH));
    assign col_last = (DATA_SIZE'(col_idx) == (size_j_q - DATA_SIZE'(1)));
    assign row_last = (row_idx == (size_i_q - DATA_SIZE'(1)));
    assign div_last = (div_cnt == CNT_W'(DATA_SIZE - 1));

    // Piecewise-linear 2^-(d): integer part shifts, fraction f gives 1 - f/2.
    always_comb begin
        exp_diff  = {max_q[DATA_SIZE-1], max_q} - {cur_elem[DATA_SIZE-1], cur_elem};
        exp_shift = exp_diff[DIFF_W-1:FRAC_SIZE];
        exp_frac  = exp_diff[FRAC_SIZE-1:0];
        exp_base  = EXP_W'(ONE_FX) - EXP_W'(exp_frac >> 1);
        if (exp_shift > SHIFT_W'(FRAC_SIZE)) begin
            exp_val = '0;
        end else begin
            exp_val = exp_base >> exp_shift;
        end
    end

    // One restoring-division step; the first step of an element seeds the
    // remainder/quotient pair from the buffered exponent.
    always_comb begin
        dividend = (2*DATA_SIZE)'(cur_elem) << FRAC_SIZE;
        if (div_cnt == '0) begin
            rem_in = REM_W'(dividend[2*DATA_SIZE-1:DATA_SIZE]);
            quo_in = dividend[DATA_SIZE-1:0];
        end else begin
            rem_in = rem_q;
            quo_in = quo_q;
        end
        rem_shift = {rem_in, quo_in[DATA_SIZE-1]};
        divisor   = (REM_W+1)'(sum_q);
        if (rem_shift >= divisor) begin
            rem_next = REM_W'(rem_shift - divisor);
            quo_next = {quo_in[DATA_SIZE-2:0], 1'b1};
        end else begin
            rem_next = REM_W'(rem_shift);
            quo_next = {quo_in[DATA_SIZE-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (START && sizes_ok) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (DATA_IN_ENABLE && col_last) begin
                    state_next = EXP;
                end
            end
            EXP: begin
                if (col_last) begin
                    state_next = DIVIDE;
                end
            end
            DIVIDE: begin
                if (div_last) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (!col_last) begin
                    state_next = DIVIDE;
                end else if (!row_last) begin
                    state_next = LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Indices, row max, sum, divider registers and the output pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            size_i_q        <= '0;
            size_j_q        <= '0;
            row_idx         <= '0;
            col_idx         <= '0;
            max_q           <= '0;
            sum_q           <= '0;
            rem_q           <= '0;
            quo_q           <= '0;
            div_cnt         <= '0;
            READY           <= 1'b0;
            ERROR           <= 1'b0;
            DATA_OUT_ENABLE <= 1'b0;
            DATA_OUT        <= '0;
        end else begin
            READY           <= 1'b0;
            ERROR           <= 1'b0;
            DATA_OUT_ENABLE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        if (sizes_ok) begin
                            size_i_q <= SIZE_I_IN;
                            size_j_q <= SIZE_J_IN;
                            row_idx  <= '0;
                            col_idx  <= '0;
                            max_q    <= '0;
                            sum_q    <= '0;
                        end else begin
                            READY <= 1'b1;
                            ERROR <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (DATA_IN_ENABLE) begin
                        if ((col_idx == '0) || ($signed(DATA_IN) > max_q)) begin
                            max_q <= $signed(DATA_IN);
                        end
                        col_idx <= col_last ? '0 : col_idx + CONTROL_SIZE'(1);
                    end
                end
                EXP: begin
                    sum_q   <= sum_q + SUM_W'(exp_val);
                    col_idx <= col_last ? '0 : col_idx + CONTROL_SIZE'(1);
                    div_cnt <= '0;
                end
                DIVIDE: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (div_last) begin
                        div_cnt         <= '0;
                        DATA_OUT        <= quo_next;
                        DATA_OUT_ENABLE <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                OUTPUT: begin
                    if (col_last) begin
                        col_idx <= '0;
                        if (row_last) begin
                            READY <= 1'b1;
                        end else begin
                            row_idx <= row_idx + DATA_SIZE'(1);
                            max_q   <= '0;
                            sum_q   <= '0;
                        end
                    end else begin
                        col_idx <= col_idx + CONTROL_SIZE'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Row buffer: raw inputs during LOAD, overwritten in place by exponents.
    always_ff @(posedge CLK) begin
        if ((state == LOAD) && DATA_IN_ENABLE) begin
            row_buf[addr] <= DATA_IN;
        end else if (state == EXP) begin
            row_buf[addr] <= DATA_SIZE'(exp_val);
        end
    end

endmodule

// File: tb/tb_matrix_softmax_stream.sv
// Testbench for matrix_softmax_stream: scenario tasks with a scoreboard
// of expected outputs and a monitor collecting what the DUT emits.

module tb_matrix_softmax_stream;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        READY;
    logic        ERROR;
    logic        DATA_IN_ENABLE;
    logic        DATA_OUT_ENABLE;
    logic [15:0] SIZE_I_IN;
    logic [15:0] SIZE_J_IN;
    logic [15:0] DATA_IN;
    logic [15:0] DATA_OUT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int exp_q[$];
    int obs_q[$];
    int obs_total     = 0;
    int ready_cnt     = 0;
    int err_cnt       = 0;
    int err_ready_cnt = 0;
    int last_out_cyc  = 0;
    int ready_cyc     = 0;
    int last_in_cyc   = 0;

    matrix_softmax_stream #(
        .DATA_SIZE   (16),
        .CONTROL_SIZE(4),
        .FRAC_SIZE   (8),
        .MAX_LENGTH  (8)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START          (START),
        .READY          (READY),
        .ERROR          (ERROR),
        .DATA_IN_ENABLE (DATA_IN_ENABLE),
        .DATA_OUT_ENABLE(DATA_OUT_ENABLE),
        .SIZE_I_IN      (SIZE_I_IN),
        .SIZE_J_IN      (SIZE_J_IN),
        .DATA_IN        (DATA_IN),
        .DATA_OUT       (DATA_OUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: outputs change only on the rising edge, so sample mid-cycle.
    always @(negedge CLK) begin
        if (DATA_OUT_ENABLE === 1'b1) begin
            obs_q.push_back(int'(DATA_OUT));
            obs_total++;
            last_out_cyc = cyc;
        end
        if (READY === 1'b1) begin
            ready_cnt++;
            ready_cyc = cyc;
            if (ERROR === 1'b1) err_ready_cnt++;
        end
        if (ERROR === 1'b1) err_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

    // Drives one matrix: START, then each row once the previous row has
    // drained, then waits (bounded) for READY.
    task automatic run_matrix(input int ni, input int nj, input int d[$],
                              input bit gaps, input bit poke, output bit timed_out);
        int base_obs;
        int base_ready;
        int w;
        timed_out  = 1'b0;
        base_obs   = obs_total;
        base_ready = ready_cnt;
        @(negedge CLK);
        START     = 1'b1;
        SIZE_I_IN = 16'(ni);
        SIZE_J_IN = 16'(nj);
        for (int r = 0; r < ni; r++) begin
            if (r == 0) begin
                @(negedge CLK);
                START     = 1'b0;
                SIZE_I_IN = 16'hFFFF;
                SIZE_J_IN = 16'hFFFF;
            end else begin
                w = 0;
                while ((obs_total - base_obs) < r * nj && w < 2000) begin
                    @(negedge CLK);
                    #1;
                    w++;
                end
                if ((obs_total - base_obs) < r * nj) begin
                    timed_out = 1'b1;
                    return;
                end
                @(negedge CLK);
            end
            for (int j = 0; j < nj; j++) begin
                if (j > 0) @(negedge CLK);
                if (gaps) begin
                    while ($urandom_range(0, 2) == 0) begin
                        DATA_IN_ENABLE = 1'b0;
                        @(negedge CLK);
                    end
                end
                DATA_IN_ENABLE = 1'b1;
                DATA_IN        = 16'(d[r * nj + j]);
                last_in_cyc    = cyc;
            end
            @(negedge CLK);
            DATA_IN_ENABLE = 1'b0;
            DATA_IN        = 16'($urandom);
            if (poke && r == 0) begin
                START     = 1'b1;
                SIZE_I_IN = 16'd1;
                SIZE_J_IN = 16'd9;
                @(negedge CLK);
                START = 1'b0;
            end
        end
        w = 0;
        while (ready_cnt == base_ready && w < 3000) begin
            @(negedge CLK);
            #1;
            w++;
        end
        if (ready_cnt == base_ready) timed_out = 1'b1;
        repeat (5) @(negedge CLK);
        #1;
    endtask

    // Independent reference for base-2 softmax with the linear fraction term.
    task automatic push_model(input int ni, input int nj, input int d[$]);
        int mx;
        int dd;
        int n;
        int f;
        int sum;
        int e[8];
        for (int r = 0; r < ni; r++) begin
            mx = d[r * nj];
            for (int j = 1; j < nj; j++) if (d[r * nj + j] > mx) mx = d[r * nj + j];
            sum = 0;
            for (int j = 0; j < nj; j++) begin
                dd   = mx - d[r * nj + j];
                n    = dd / 256;
                f    = dd % 256;
                e[j] = (n > 8) ? 0 : ((256 - f / 2) >> n);
                sum += e[j];
            end
            for (int j = 0; j < nj; j++) exp_q.push_back((e[j] * 256) / sum);
        end
    endtask

    task automatic test_reset();
        RST            = 1'b0;
        START          = 1'b0;
        DATA_IN_ENABLE = 1'b0;
        SIZE_I_IN      = '0;
        SIZE_J_IN      = '0;
        DATA_IN        = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", READY); end
        checks++;
        if (ERROR !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", ERROR); end
        checks++;
        if (DATA_OUT_ENABLE !== 1'b0) begin errors++; $display("FAIL reset_dout_en: got %b expected 0", DATA_OUT_ENABLE); end
        checks++;
        if (DATA_OUT !== 16'd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", DATA_OUT); end
        RST = 1'b1;
        repeat (6) @(negedge CLK);
        #1;
        checks++;
        if (obs_total !== 0) begin errors++; $display("FAIL reset_idle_out: got %0d pulses expected 0", obs_total); end
        checks++;
        if (ready_cnt !== 0) begin errors++; $display("FAIL reset_idle_ready: got %0d pulses expected 0", ready_cnt); end
    endtask

    task automatic test_single_row();
        int    in_tab[4][2]  = '{'{0, 0}, '{256, 0}, '{0, -128}, '{0, -2560}};
        int    out_tab[4][2] = '{'{128, 128}, '{170, 85}, '{146, 109}, '{256, 0}};
        string name[4]       = '{"equal", "ratio", "neg_half", "underflow"};
        int    d[$];
        int    got;
        int    want;
        int    r0;
        bit    to;
        for (int k = 0; k < 4; k++) begin
            d = '{in_tab[k][0], in_tab[k][1]};
            exp_q.push_back(out_tab[k][0]);
            exp_q.push_back(out_tab[k][1]);
            r0 = ready_cnt;
            run_matrix(1, 2, d, 1'b0, 1'b0, to);
            checks++;
            if (to !== 1'b0) begin errors++; $display("FAIL %s_timeout: READY not seen within budget", name[k]); end
            while (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if (obs_q.size() == 0) begin
                    errors++; $display("FAIL %s_data: got no output expected %0d", name[k], want);
                end else begin
                    got = obs_q.pop_front();
                    if (got !== want) begin errors++; $display("FAIL %s_data: got %0d expected %0d", name[k], got, want); end
                end
            end
            checks++;
            if (obs_q.size() != 0) begin errors++; $display("FAIL %s_extra: got %0d extra outputs expected 0", name[k], obs_q.size()); obs_q.delete(); end
            checks++;
            if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL %s_ready_count: got %0d expected 1", name[k], ready_cnt - r0); end
            checks++;
            if (ready_cyc - last_out_cyc !== 1) begin errors++; $display("FAIL %s_ready_timing: got %0d cycles expected 1", name[k], ready_cyc - last_out_cyc); end
            checks++;
            if (last_out_cyc - last_in_cyc !== 36) begin errors++; $display("FAIL %s_latency: got %0d cycles expected 36", name[k], last_out_cyc - last_in_cyc); end
        end
    endtask

    task automatic test_two_rows();
        int d[$];
        int got;
        int want;
        int r0;
        int e0;
        bit to;
        d = '{0, 0, 256, 0};
        exp_q.push_back(128);
        exp_q.push_back(128);
        exp_q.push_back(170);
        exp_q.push_back(85);
        r0 = ready_cnt;
        e0 = err_cnt;
        run_matrix(2, 2, d, 1'b0, 1'b1, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL two_rows_timeout: READY not seen within budget"); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL two_rows_data: got no output expected %0d", want);
            end else begin
                got = obs_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL two_rows_data: got %0d expected %0d", got, want); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL two_rows_extra: got %0d extra outputs expected 0", obs_q.size()); obs_q.delete(); end
        checks++;
        if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL two_rows_ready_count: got %0d expected 1", ready_cnt - r0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL two_rows_start_ignored: got %0d error pulses expected 0", err_cnt - e0); end
        checks++;
        if (last_out_cyc - last_in_cyc !== 36) begin errors++; $display("FAIL two_rows_latency: got %0d cycles expected 36", last_out_cyc - last_in_cyc); end
    endtask

    task automatic test_errors();
        int    si[3]   = '{1, 0, 1};
        int    sj[3]   = '{9, 2, 0};
        string name[3] = '{"j_too_big", "i_zero", "j_zero"};
        int    e0;
        int    b0;
        int    o0;
        for (int k = 0; k < 3; k++) begin
            e0 = err_cnt;
            b0 = err_ready_cnt;
            o0 = obs_total;
            @(negedge CLK);
            START     = 1'b1;
            SIZE_I_IN = 16'(si[k]);
            SIZE_J_IN = 16'(sj[k]);
            @(negedge CLK);
            START = 1'b0;
            DATA_IN_ENABLE = 1'b1;
            repeat (4) @(negedge CLK);
            DATA_IN_ENABLE = 1'b0;
            #1;
            checks++;
            if (err_cnt - e0 !== 1) begin errors++; $display("FAIL %s_error_pulses: got %0d expected 1", name[k], err_cnt - e0); end
            checks++;
            if (err_ready_cnt - b0 !== 1) begin errors++; $display("FAIL %s_error_with_ready: got %0d expected 1", name[k], err_ready_cnt - b0); end
            checks++;
            if (obs_total - o0 !== 0) begin errors++; $display("FAIL %s_no_data: got %0d outputs expected 0", name[k], obs_total - o0); end
        end
    endtask

    task automatic test_reset_mid();
        int d[$];
        int got;
        int want;
        int r0;
        int o0;
        bit to;
        @(negedge CLK);
        START     = 1'b1;
        SIZE_I_IN = 16'd1;
        SIZE_J_IN = 16'd2;
        @(negedge CLK);
        START          = 1'b0;
        DATA_IN_ENABLE = 1'b1;
        DATA_IN        = 16'd0;
        @(negedge CLK);
        DATA_IN = 16'd0;
        @(negedge CLK);
        DATA_IN_ENABLE = 1'b0;
        repeat (8) @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if (DATA_OUT !== 16'd0) begin errors++; $display("FAIL midreset_dout: got %0d expected 0", DATA_OUT); end
        checks++;
        if ({READY, ERROR, DATA_OUT_ENABLE} !== 3'b000) begin errors++; $display("FAIL midreset_flags: got %b expected 000", {READY, ERROR, DATA_OUT_ENABLE}); end
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        obs_q.delete();
        exp_q.delete();
        r0 = ready_cnt;
        o0 = obs_total;
        repeat (60) @(negedge CLK);
        #1;
        checks++;
        if (obs_total - o0 !== 0) begin errors++; $display("FAIL midreset_abandon_data: got %0d outputs expected 0", obs_total - o0); end
        checks++;
        if (ready_cnt - r0 !== 0) begin errors++; $display("FAIL midreset_abandon_ready: got %0d pulses expected 0", ready_cnt - r0); end
        d = '{0, 0};
        exp_q.push_back(128);
        exp_q.push_back(128);
        run_matrix(1, 2, d, 1'b0, 1'b0, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL midreset_restart_timeout: READY not seen within budget"); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL midreset_restart_data: got no output expected %0d", want);
            end else begin
                got = obs_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL midreset_restart_data: got %0d expected %0d", got, want); end
            end
        end
        checks++;
        if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL midreset_restart_ready: got %0d expected 1", ready_cnt - r0); end
    endtask

    task automatic test_back_to_back();
        int ni_tab[4]  = '{2, 3, 1, 2};
        int nj_tab[4]  = '{8, 1, 5, 3};
        int span[4]    = '{32768, 2048, 1024, 300};
        int d[$];
        int got;
        int want;
        int r0;
        bit to;
        for (int k = 0; k < 4; k++) begin
            d.delete();
            for (int n = 0; n < ni_tab[k] * nj_tab[k]; n++) begin
                d.push_back($urandom_range(0, 2 * span[k] - 1) - span[k]);
            end
            push_model(ni_tab[k], nj_tab[k], d);
            r0 = ready_cnt;
            run_matrix(ni_tab[k], nj_tab[k], d, 1'b1, 1'b0, to);
            checks++;
            if (to !== 1'b0) begin errors++; $display("FAIL b2b%0d_timeout: READY not seen within budget", k); end
            while (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if (obs_q.size() == 0) begin
                    errors++; $display("FAIL b2b%0d_data: got no output expected %0d", k, want);
                end else begin
                    got = obs_q.pop_front();
                    if (got !== want) begin errors++; $display("FAIL b2b%0d_data: got %0d expected %0d", k, got, want); end
                end
            end
            checks++;
            if (obs_q.size() != 0) begin errors++; $display("FAIL b2b%0d_extra: got %0d extra outputs expected 0", k, obs_q.size()); obs_q.delete(); end
            checks++;
            if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL b2b%0d_ready_count: got %0d expected 1", k, ready_cnt - r0); end
            checks++;
            if (last_out_cyc - last_in_cyc !== 18 * nj_tab[k]) begin
                errors++; $display("FAIL b2b%0d_latency: got %0d cycles expected %0d", k, last_out_cyc - last_in_cyc, 18 * nj_tab[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_errors();
        test_two_rows();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_softmax_stream.md
MATRIX_SOFTMAX_STREAM -- requirements
Module: matrix_softmax_stream

Interface
REQ-001 Parameter DATA_SIZE, default 16, data word width.
REQ-002 Parameter CONTROL_SIZE, default 4, index counter width.
REQ-003 Parameter FRAC_SIZE, default 8, fractional bits of fixed-point data; ONE_FX = 2^FRAC_SIZE.
REQ-004 Parameter MAX_LENGTH, default 8, row buffer depth; MAX_LENGTH SHALL be at most 2^CONTROL_SIZE.
REQ-005 CLK  input  1  single clock; all logic on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-low.
REQ-007 START  input  1  begin matrix operation; sampled only in IDLE.
REQ-008 READY  output  1  one-cycle completion pulse.
REQ-009 ERROR  output  1  one-cycle pulse on rejected START.
REQ-010 DATA_IN_ENABLE  input  1  DATA_IN valid; honoured only in LOAD.
REQ-011 DATA_OUT_ENABLE  output  1  DATA_OUT valid, one-cycle pulse per element.
REQ-012 SIZE_I_IN  input  DATA_SIZE  row count; latched at START.
REQ-013 SIZE_J_IN  input  DATA_SIZE  row length; latched at START.
REQ-014 DATA_IN  input  DATA_SIZE  signed two's-complement element, FRAC_SIZE fractional bits.
REQ-015 DATA_OUT  output  DATA_SIZE  unsigned softmax result, FRAC_SIZE fractional bits.

Function
REQ-016 The block SHALL compute base-2 row-wise softmax, y = 2^(x-max)/sum(2^(x-max)), independently per row, rows in order, elements in input order.
REQ-017 FSM states SHALL be IDLE, LOAD, EXP, DIVIDE, OUTPUT; reset state IDLE.
REQ-018 IDLE: on START=1 with 1<=SIZE_I_IN and 1<=SIZE_J_IN<=MAX_LENGTH, latch sizes, clear row/column indices, go to LOAD.
REQ-019 IDLE: on START=1 with any size out of range, pulse ERROR and READY for one cycle together, stay IDLE, emit no data.
REQ-020 LOAD: each cycle with DATA_IN_ENABLE=1 SHALL write DATA_IN to buffer[col] and update signed running max (first element of row initialises max); after SIZE_J_IN-th element go to EXP next cycle.
REQ-021 EXP: one element per cycle, d = max - x (unsigned, DATA_SIZE+1 bits), n = d >> FRAC_SIZE, f = d mod ONE_FX; e = (ONE_FX - f/2) >> n, e = 0 when n > FRAC_SIZE; e overwrites buffer entry; sum += e; SIZE_J_IN cycles, then DIVIDE.
REQ-022 Sum accumulator SHALL be DATA_SIZE+CONTROL_SIZE bits, cleared at row start; sum >= ONE_FX always (max element gives e = ONE_FX), so no divide-by-zero.
REQ-023 DIVIDE: restoring sequential division of (e << FRAC_SIZE) by sum, floor, one quotient bit per cycle, exactly DATA_SIZE cycles per element, then OUTPUT.
REQ-024 OUTPUT: DATA_OUT = quotient (zero-extended), DATA_OUT_ENABLE=1 for exactly one cycle; then next element DIVIDE, or next row LOAD, or IDLE after last element of last row.
REQ-025 READY SHALL pulse one cycle, the cycle after final DATA_OUT_ENABLE.
REQ-026 DATA_OUT SHALL hold its last value between pulses.
REQ-027 START outside IDLE and DATA_IN_ENABLE outside LOAD SHALL be ignored; changes to SIZE_* after START SHALL have no effect.
REQ-028 Per-row latency after last input: SIZE_J_IN EXP cycles + SIZE_J_IN*(DATA_SIZE+1) cycles to last output.

Reset
REQ-029 RST=0 SHALL asynchronously force IDLE, READY=0, ERROR=0, DATA_OUT_ENABLE=0, DATA_OUT=0, indices, max and sum to 0.
REQ-030 Reset mid-operation SHALL abandon the matrix; no further output pulses until a new START.
REQ-031 Buffer contents need not be reset.

Verification (DATA_SIZE=16, FRAC_SIZE=8, MAX_LENGTH=8)
REQ-032 I=1,J=2, inputs [0,0] -> outputs 128,128; READY one cycle after second pulse.
REQ-033 I=1,J=2, inputs [256,0] -> e 256,128, sum 384 -> outputs 170,85.
REQ-034 I=1,J=2, inputs [0,-128] -> e 256,192, sum 448 -> outputs 146,109; inputs [0,-2560] -> outputs 256,0.
REQ-035 I=2,J=2, rows [0,0],[256,0] -> outputs 128,128,170,85 in order, single READY at end; START pulsed mid-run ignored.
REQ-036 START with SIZE_J_IN=9 or SIZE_I_IN=0 -> ERROR and READY pulse same cycle, no DATA_OUT_ENABLE.
REQ-037 RST low during DIVIDE of row 0 -> all outputs 0 immediately; fresh START with [0,0] -> outputs 128,128.
